// File: rtl/nco_multichannel.sv
// rtl/nco_multichannel.sv - time-multiplexed multichannel NCO sharing one waveform stage
// Optional feature: define NCO_DITHER_EN to add LFSR dither to the phase before truncation.
module nco_multichannel #(
    parameter int NUM_CH     = 4,
    parameter int PHASE_W    = 32,
    parameter int BIT_DEPTH  = 12,
    parameter int SAMPLE_DIV = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [1:0]           cfg_addr,
    input  logic [PHASE_W-1:0]   cfg_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [BIT_DEPTH-1:0] out_sample,
    output logic                 overrun
);

    localparam int N     = BIT_DEPTH;
    localparam int H     = 1 << (N - 1);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int SHIFT = PHASE_W - N;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_t;

    logic [PHASE_W-1:0] tw_q   [NUM_CH];
    logic [PHASE_W-1:0] off_q  [NUM_CH];
    logic [1:0]         wave_q [NUM_CH];
    logic [N-1:0]       duty_q [NUM_CH];
    logic [PHASE_W-1:0] acc_q  [NUM_CH];

    logic [CNT_W-1:0]   cnt_q;
    logic               tick;
    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               issue;
    logic               ovr_set;
    logic               stall;

    logic [PHASE_W-1:0] ph_sum;
    logic [N-1:0]       p_issue;

    logic               s1_valid;
    logic [CH_W-1:0]    s1_ch;
    logic [N-1:0]       s1_p;
    logic [1:0]         s1_wave;
    logic [N-1:0]       s1_duty;

    logic [N-2:0]       x;
    logic [N-1:0]       hx;
    logic [2*N-3:0]     prod;
    logic [2*N-3:0]     prod_sh;
    logic [N-2:0]       y;
    logic [N-1:0]       tri_v;
    logic [N-1:0]       wave_d;

    // Register writes land at the clock edge, so an issue in the same cycle sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tw_q[i]   <= '0;
                off_q[i]  <= '0;
                wave_q[i] <= '0;
                duty_q[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            case (cfg_addr)
                2'd0:    tw_q[cfg_ch]   <= cfg_wdata;
                2'd1:    off_q[cfg_ch]  <= cfg_wdata;
                2'd2:    wave_q[cfg_ch] <= cfg_wdata[1:0];
                default: duty_q[cfg_ch] <= cfg_wdata[N-1:0];
            endcase
        end
    end

    assign tick = enable && (cnt_q == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall = out_valid && !out_ready;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        issue   = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SWEEP;
                    ch_d    = '0;
                end
            end
            S_SWEEP: begin
                ovr_set = tick;
                if (!stall) begin
                    issue = 1'b1;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef NCO_DITHER_EN
    localparam int DW = (SHIFT < 16) ? SHIFT : 16;

    logic [15:0] lfsr_q;

    // Steps only on an actual issue, so stalls leave the dither sequence untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else if (issue) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign ph_sum = acc_q[ch_q] + off_q[ch_q] + PHASE_W'(lfsr_q[DW-1:0]);
`else
    assign ph_sum = acc_q[ch_q] + off_q[ch_q];
`endif

    assign p_issue = N'(ph_sum >> SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (issue) begin
            acc_q[ch_q] <= acc_q[ch_q] + tw_q[ch_q];
        end
    end

    // Stage 1: capture the issued channel's phase and waveform settings together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_p     <= '0;
            s1_wave  <= '0;
            s1_duty  <= '0;
        end else if (!stall) begin
            s1_valid <= issue;
            if (issue) begin
                s1_ch   <= ch_q;
                s1_p    <= p_issue;
                s1_wave <= wave_q[ch_q];
                s1_duty <= duty_q[ch_q];
            end
        end
    end

    // Sine approximated by two parabolas; the peak of x*(H-x) overshoots by one and saturates.
    always_comb begin
        x       = s1_p[N-2:0];
        hx      = N'(H) - {1'b0, x};
        prod    = {{(N-1){1'b0}}, x} * {{(N-2){1'b0}}, hx};
        prod_sh = prod >> (N - 3);
        y       = (prod_sh > (2*N-2)'(H - 1)) ? (N-1)'(H - 1) : (N-1)'(prod_sh);
        tri_v   = s1_p[N-1] ? ~s1_p : s1_p;
        case (s1_wave)
            2'd0:    wave_d = s1_p[N-1] ? (N'(H - 1) - {1'b0, y}) : (N'(H) + {1'b0, y});
            2'd1:    wave_d = N'({tri_v, 1'b0});
            2'd2:    wave_d = s1_p;
            default: wave_d = (s1_p < s1_duty) ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_sample <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ch     <= s1_ch;
                out_sample <= wave_d;
            end
        end
    end

endmodule
